// File: rtl/fpu_classify_pipe.sv
// fpu_classify_pipe: one-stage registered unpack of IEEE operands into sign/exponent/significand
// plus a RISC-V fclass mask per operand, with valid/ready handshake and a sticky invalid flag.
module fpu_classify_pipe #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int NUM_OPS = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_OPS*(1+EXP_W+MAN_W)-1:0] in_ops,
  input  logic [NUM_OPS-1:0]                 in_op_en,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_OPS-1:0]                 out_sign,
  output logic [NUM_OPS*EXP_W-1:0]           out_exp,
  output logic [NUM_OPS*(MAN_W+1)-1:0]       out_sig,
  output logic [NUM_OPS*10-1:0]              out_class,
  output logic                               out_snan_any,
  input  logic                               clear_nv,
  output logic                               nv_sticky
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;

  localparam int CLS_NEG_INF  = 0;
  localparam int CLS_NEG_NORM = 1;
  localparam int CLS_NEG_SUB  = 2;
  localparam int CLS_NEG_ZERO = 3;
  localparam int CLS_POS_ZERO = 4;
  localparam int CLS_POS_SUB  = 5;
  localparam int CLS_POS_NORM = 6;
  localparam int CLS_POS_INF  = 7;
  localparam int CLS_SNAN     = 8;
  localparam int CLS_QNAN     = 9;

  // One-hot fclass mask; the fraction MSB is the quiet bit, and NaN bits ignore the sign.
  function automatic logic [9:0] fclass_mask(input logic             sign,
                                             input logic [EXP_W-1:0] exp_f,
                                             input logic [MAN_W-1:0] frac);
    logic [9:0] mask;
    logic       exp_zero;
    logic       exp_ones;
    logic       frac_zero;
    mask      = 10'd0;
    exp_zero  = (exp_f == {EXP_W{1'b0}});
    exp_ones  = (exp_f == {EXP_W{1'b1}});
    frac_zero = (frac == {MAN_W{1'b0}});
    if (exp_ones) begin
      if (frac_zero) begin
        if (sign) mask[CLS_NEG_INF] = 1'b1;
        else      mask[CLS_POS_INF] = 1'b1;
      end else if (frac[MAN_W-1]) begin
        mask[CLS_QNAN] = 1'b1;
      end else begin
        mask[CLS_SNAN] = 1'b1;
      end
    end else if (exp_zero) begin
      if (frac_zero) begin
        if (sign) mask[CLS_NEG_ZERO] = 1'b1;
        else      mask[CLS_POS_ZERO] = 1'b1;
      end else begin
        if (sign) mask[CLS_NEG_SUB] = 1'b1;
        else      mask[CLS_POS_SUB] = 1'b1;
      end
    end else begin
      if (sign) mask[CLS_NEG_NORM] = 1'b1;
      else      mask[CLS_POS_NORM] = 1'b1;
    end
    return mask;
  endfunction

  // Significand with the hidden bit restored for every nonzero exponent.
  function automatic logic [SIG_W-1:0] full_sig(input logic [EXP_W-1:0] exp_f,
                                                input logic [MAN_W-1:0] frac);
    return {(exp_f != {EXP_W{1'b0}}), frac};
  endfunction

  logic [NUM_OPS-1:0]       sign_s;
  logic [NUM_OPS*EXP_W-1:0] exp_s;
  logic [NUM_OPS*SIG_W-1:0] sig_s;
  logic [NUM_OPS*10-1:0]    class_s;
  logic                     snan_s;
  logic                     accept_s;

  logic                     out_valid_r;
  logic [NUM_OPS-1:0]       sign_r;
  logic [NUM_OPS*EXP_W-1:0] exp_r;
  logic [NUM_OPS*SIG_W-1:0] sig_r;
  logic [NUM_OPS*10-1:0]    class_r;
  logic                     snan_r;
  logic                     nv_r;

  assign in_ready = !out_valid_r || out_ready;
  assign accept_s = in_valid && in_ready;

  // Unpack and classify every operand; disabled lanes are forced to zero.
  always_comb begin
    sign_s  = {NUM_OPS{1'b0}};
    exp_s   = {(NUM_OPS*EXP_W){1'b0}};
    sig_s   = {(NUM_OPS*SIG_W){1'b0}};
    class_s = {(NUM_OPS*10){1'b0}};
    snan_s  = 1'b0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (in_op_en[i]) begin
        sign_s[i]                 = in_ops[i*W + W - 1];
        exp_s[i*EXP_W +: EXP_W]   = in_ops[i*W + MAN_W +: EXP_W];
        sig_s[i*SIG_W +: SIG_W]   = full_sig(in_ops[i*W + MAN_W +: EXP_W], in_ops[i*W +: MAN_W]);
        class_s[i*10 +: 10]       = fclass_mask(in_ops[i*W + W - 1],
                                                in_ops[i*W + MAN_W +: EXP_W],
                                                in_ops[i*W +: MAN_W]);
      end else begin
        sign_s[i]                 = 1'b0;
        exp_s[i*EXP_W +: EXP_W]   = {EXP_W{1'b0}};
        sig_s[i*SIG_W +: SIG_W]   = {SIG_W{1'b0}};
        class_s[i*10 +: 10]       = 10'd0;
      end
    end
    // Disabled lanes carry a zero mask, so a plain OR covers only enabled operands.
    for (int i = 0; i < NUM_OPS; i++) begin
      snan_s = snan_s | class_s[i*10 + CLS_SNAN];
    end
  end

  // Output stage: load on acceptance, hold otherwise; valid drops once drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      sign_r      <= {NUM_OPS{1'b0}};
      exp_r       <= {(NUM_OPS*EXP_W){1'b0}};
      sig_r       <= {(NUM_OPS*SIG_W){1'b0}};
      class_r     <= {(NUM_OPS*10){1'b0}};
      snan_r      <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      sign_r      <= sign_s;
      exp_r       <= exp_s;
      sig_r       <= sig_s;
      class_r     <= class_s;
      snan_r      <= snan_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Sticky invalid flag; a setting acceptance takes priority over clear_nv.
  always_ff @(posedge clk) begin
    if (rst) begin
      nv_r <= 1'b0;
    end else if (accept_s && snan_s) begin
      nv_r <= 1'b1;
    end else if (clear_nv) begin
      nv_r <= 1'b0;
    end else begin
      nv_r <= nv_r;
    end
  end

  assign out_valid    = out_valid_r;
  assign out_sign     = sign_r;
  assign out_exp      = exp_r;
  assign out_sig      = sig_r;
  assign out_class    = class_r;
  assign out_snan_any = snan_r;
  assign nv_sticky    = nv_r;

endmodule

// File: tb/tb_fpu_classify_pipe.sv
// Scoreboard bench for fpu_classify_pipe at default parameters (binary32, three operands).
module tb_fpu_classify_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_ops;
  logic [2:0]  in_op_en;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_sign;
  logic [23:0] out_exp;
  logic [71:0] out_sig;
  logic [29:0] out_class;
  logic        out_snan_any;
  logic        clear_nv;
  logic        nv_sticky;

  always #5 clk = ~clk;

  fpu_classify_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ops(in_ops), .in_op_en(in_op_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_sig(out_sig), .out_class(out_class),
    .out_snan_any(out_snan_any), .clear_nv(clear_nv), .nv_sticky(nv_sticky)
  );

  typedef struct packed {
    logic [2:0]  sign;
    logic [23:0] exp;
    logic [71:0] sig;
    logic [29:0] cls;
    logic        snan;
  } res_t;

  res_t sb[$];
  res_t last_r;
  logic model_nv;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, want);
    end
  endtask

  function automatic res_t ref_result(input logic [95:0] ops, input logic [2:0] en);
    res_t        r;
    logic [31:0] op;
    int          idx;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      op = ops[i*32 +: 32];
      if (en[i]) begin
        if (op[30:23] == 8'hFF)
          idx = (op[22:0] == 23'd0) ? (op[31] ? 0 : 7) : (op[22] ? 9 : 8);
        else if (op[30:23] == 8'h00)
          idx = (op[22:0] == 23'd0) ? (op[31] ? 3 : 4) : (op[31] ? 2 : 5);
        else
          idx = op[31] ? 1 : 6;
        r.sign[i]         = op[31];
        r.exp[i*8 +: 8]   = op[30:23];
        r.sig[i*24 +: 24] = {(op[30:23] != 8'h00), op[22:0]};
        r.cls[i*10 +: 10] = 10'd1 << idx;
        if (idx == 8) r.snan = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [95:0] pack3(input logic [31:0] op0, input logic [31:0] op1,
                                        input logic [31:0] op2);
    return {op2, op1, op0};
  endfunction

  task automatic check_outputs();
    res_t e;
    e = (sb.size() != 0) ? sb[0] : last_r;
    check_val("out_valid", out_valid, (sb.size() != 0));
    check_val("nv_sticky", nv_sticky, model_nv);
    check_val("out_sign", out_sign, e.sign);
    check_val("out_exp", out_exp, e.exp);
    check_val("out_sig", out_sig, e.sig);
    check_val("out_class", out_class, e.cls);
    check_val("out_snan_any", out_snan_any, e.snan);
  endtask

  // Called just after a falling edge: drive, update model, advance one clock, check.
  task automatic cycle(input logic v, input logic [95:0] ops, input logic [2:0] en,
                       input logic rdy, input logic clr, input logic r);
    logic model_ready;
    logic acc;
    res_t e;
    rst = r; in_valid = v; in_ops = ops; in_op_en = en; out_ready = rdy; clear_nv = clr;
    model_ready = (sb.size() == 0) || rdy;
    #1;
    check_val("in_ready", in_ready, model_ready);
    acc = !r && v && model_ready;
    if (r) begin
      sb.delete();
      last_r   = '0;
      model_nv = 1'b0;
    end else begin
      if (sb.size() != 0 && rdy) last_r = sb.pop_front();
      if (acc) begin
        e = ref_result(ops, en);
        sb.push_back(e);
      end
      if (acc && e.snan) model_nv = 1'b1;
      else if (clr)      model_nv = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  logic [31:0] pats [12] = '{32'h00000000, 32'h00000001, 32'h007FFFFF, 32'h00800000,
                             32'h3F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h7F800001,
                             32'h7FBFFFFF, 32'h7FC00000, 32'h7FFFFFFF, 32'h40490FDB};
  logic [95:0] snan_ops;
  logic [95:0] rops;
  logic [31:0] op;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ops = 96'd0; in_op_en = 3'b000;
    out_ready = 1'b1; clear_nv = 1'b0;
    model_nv = 1'b0; last_r = '0;
    snan_ops = pack3(32'h7FA00000, 32'h7FC00000, 32'h00000001);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();

    // +1.0, -0.0, +inf
    cycle(1'b1, pack3(32'h3F800000, 32'h80000000, 32'h7F800000), 3'b111, 1'b1, 1'b0, 1'b0);
    check_val("basic.class", out_class, {10'h080, 10'h008, 10'h040});
    check_val("basic.sig0", out_sig[23:0], 24'h800000);
    check_val("basic.snan", out_snan_any, 1'b0);

    // sNaN, qNaN, +subnormal; flag holds after in_valid drops
    cycle(1'b1, snan_ops, 3'b111, 1'b1, 1'b0, 1'b0);
    check_val("nan.class", out_class, {10'h020, 10'h200, 10'h100});
    check_val("nan.snan", out_snan_any, 1'b1);
    check_val("nan.nv", nv_sticky, 1'b1);
    cycle(1'b0, 96'd0, 3'b000, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 96'd0, 3'b000, 1'b1, 1'b0, 1'b0);
    check_val("nan.nv_hold", nv_sticky, 1'b1);

    // sNaN lane disabled
    cycle(1'b1, snan_ops, 3'b110, 1'b1, 1'b0, 1'b0);
    check_val("dis.class0", out_class[9:0], 10'h000);
    check_val("dis.sign0", out_sign[0], 1'b0);
    check_val("dis.exp0", out_exp[7:0], 8'h00);
    check_val("dis.sig0", out_sig[23:0], 24'h000000);
    check_val("dis.snan", out_snan_any, 1'b0);
    check_val("dis.nv", nv_sticky, 1'b1);

    // Backpressure for five cycles, then a four-transaction stream
    cycle(1'b0, 96'd0, 3'b000, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, pack3(32'h40490FDB, 32'hC0000000, 32'h00800000), 3'b111, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, pack3(pats[k], pats[k+1], pats[k+2]), 3'b111, 1'b0, 1'b0, 1'b0);
      check_val("bp.class", out_class, {10'h040, 10'h002, 10'h040});
    end
    for (int k = 0; k < 4; k++)
      cycle(1'b1, pack3(pats[k+4], pats[k+5], pats[k+6]), 3'b111, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 96'd0, 3'b000, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 96'd0, 3'b000, 1'b1, 1'b0, 1'b0);

    // Clear, set, set-wins-over-clear, then clear alone
    cycle(1'b0, 96'd0, 3'b000, 1'b1, 1'b1, 1'b0);
    check_val("clr.nv0", nv_sticky, 1'b0);
    cycle(1'b1, snan_ops, 3'b111, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, snan_ops, 3'b111, 1'b1, 1'b1, 1'b0);
    check_val("clr.setwins", nv_sticky, 1'b1);
    cycle(1'b0, 96'd0, 3'b000, 1'b1, 1'b1, 1'b0);
    check_val("clr.alone", nv_sticky, 1'b0);

    // Random mix of special patterns, enables, backpressure and clears
    for (int n = 0; n < 60; n++) begin
      for (int j = 0; j < 3; j++) begin
        op = pats[$urandom_range(0, 11)];
        if ($urandom_range(0, 1) == 1) op[31] = ~op[31];
        rops[j*32 +: 32] = op;
      end
      cycle($urandom_range(0, 3) != 0, rops, 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 1'b0);
    end
    cycle(1'b0, 96'd0, 3'b000, 1'b1, 1'b0, 1'b0);

    // Reset while a result is stalled
    cycle(1'b1, snan_ops, 3'b111, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 96'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    check_val("rst.pre_valid", out_valid, 1'b1);
    check_val("rst.pre_nv", nv_sticky, 1'b1);
    cycle(1'b1, snan_ops, 3'b111, 1'b0, 1'b0, 1'b1);
    check_val("rst.valid", out_valid, 1'b0);
    check_val("rst.nv", nv_sticky, 1'b0);
    check_val("rst.class", out_class, 30'd0);
    check_val("rst.sig", out_sig, 72'd0);
    cycle(1'b1, pack3(32'h3F800000, 32'h80000000, 32'h7F800000), 3'b111, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 96'd0, 3'b000, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_classify_pipe.md
FPU_CLASSIFY_PIPE -- requirements
Module: fpu_classify_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width; W = 1+EXP_W+MAN_W.
REQ-003 SHALL have parameter NUM_OPS, default 3, operand channel count (1..8).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  input transaction valid.
REQ-007 in_ready  output  1  block can accept input this cycle.
REQ-008 in_ops  input  NUM_OPS*W  packed IEEE operands; operand i at bits [i*W +: W].
REQ-009 in_op_en  input  NUM_OPS  per-operand enable; bit i qualifies operand i.
REQ-010 out_valid  output  1  output transaction valid.
REQ-011 out_ready  input  1  downstream accepts output.
REQ-012 out_sign  output  NUM_OPS  sign bit per operand.
REQ-013 out_exp  output  NUM_OPS*EXP_W  raw biased exponent field per operand.
REQ-014 out_sig  output  NUM_OPS*(MAN_W+1)  significand with hidden bit per operand.
REQ-015 out_class  output  NUM_OPS*10  per-operand RISC-V fclass mask.
REQ-016 out_snan_any  output  1  any enabled operand of this transaction is sNaN.
REQ-017 clear_nv  input  1  clears sticky invalid flag.
REQ-018 nv_sticky  output  1  sticky invalid flag.

Function
REQ-019 SHALL accept a transaction when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-020 SHALL present results registered one cycle after acceptance (latency 1); out_valid asserts the cycle after acceptance.
REQ-021 SHALL hold all out_* stable while out_valid && !out_ready; no transaction lost or duplicated.
REQ-022 SHALL deassert out_valid after out_valid && out_ready when no new transaction is accepted that cycle; back-to-back accept with out_ready=1 SHALL sustain one transaction per cycle.
REQ-023 Per enabled operand: exp==0 & frac==0 -> zero; exp==0 & frac!=0 -> subnormal; exp all-ones & frac==0 -> inf; exp all-ones & frac MSB=1 -> qNaN; exp all-ones & frac MSB=0 & frac!=0 -> sNaN; else normal.
REQ-024 out_class bit order SHALL be: 0 -inf, 1 -normal, 2 -subnormal, 3 -zero, 4 +zero, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN; exactly one bit set for enabled operands; NaN bits ignore sign.
REQ-025 out_sig hidden bit SHALL be 1 iff exp field != 0; low MAN_W bits = fraction.
REQ-026 Disabled operand (in_op_en[i]=0) SHALL produce all-zero sign, exp, sig and class fields and SHALL NOT contribute to out_snan_any or nv_sticky.
REQ-027 out_snan_any SHALL be OR of class bit 8 over enabled operands of the registered transaction.
REQ-028 nv_sticky SHALL set on the cycle after acceptance of a transaction with any enabled sNaN, and remain set until clear_nv.
REQ-029 clear_nv SHALL clear nv_sticky next cycle; simultaneous clear_nv and setting acceptance SHALL leave nv_sticky=1 (set wins).
REQ-030 in_valid=0 SHALL leave all output registers unchanged except out_valid per REQ-022.

Reset
REQ-031 While rst=1 at a clock edge: out_valid=0, nv_sticky=0, all data outputs and out_snan_any=0 next cycle.
REQ-032 Reset mid-transaction SHALL discard pending output; no acceptance occurs in a reset cycle; in_ready SHALL be 1 the cycle after reset.

Verification
REQ-033 Defaults, ops {0x3F800000, 0x80000000, 0x7F800000}, en=3'b111 -> next cycle out_valid=1, classes {0x040, 0x008, 0x080}, out_sig[0]=0x800000, out_snan_any=0.
REQ-034 ops {0x7FA00000, 0x7FC00000, 0x00000001} -> classes {0x100, 0x200, 0x020}, out_snan_any=1, nv_sticky=1 next cycle and held after in_valid drops.
REQ-035 Same sNaN op with en=3'b110 -> operand 0 outputs all zero, out_snan_any=0, nv_sticky unchanged.
REQ-036 out_ready=0 for 5 cycles after a result -> outputs stable, in_ready=0; new in_valid not accepted until out_ready=1; then streaming 4 transactions back-to-back yields 4 outputs in order.
REQ-037 nv_sticky=1, assert clear_nv same cycle as accepting sNaN transaction -> nv_sticky stays 1; clear_nv alone next -> 0.
REQ-038 rst asserted while out_valid=1 and out_ready=0 -> out_valid=0, nv_sticky=0, all outputs 0; in_ready=1 after release.
